// File: rtl/multu_ctrl.sv
// Unsigned 32x32 shift-add multiplier with HI/LO registers; 34 cycles start->result (IDLE, 32 x RUN, DONE).
// Stalls the EX stage while busy if EX holds MULTU/MFHI/MFLO/MTHI/MTLO; such requests are ignored until IDLE.
module multu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [63:0] product_q;
  logic [31:0] mcand_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        done_q;
  logic [32:0] sum_d;

  // Carry out of the add is kept so it shifts into product[63].
  always_comb begin
    sum_d = {1'b0, product_q[63:32]};
    if (product_q[0]) begin
      sum_d = {1'b0, product_q[63:32]} + {1'b0, mcand_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      product_q <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start) begin
            product_q <= {32'b0, op_b};
            mcand_q   <= op_a;
            count_q   <= '0;
            state_q   <= RUN;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          product_q <= {sum_d, product_q[31:1]};
          count_q   <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          hi_q    <= product_q[63:32];
          lo_q    <= product_q[31:0];
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign stall  = busy_q & (start | mfhi_req | mflo_req | mthi | mtlo);

endmodule

// File: tb/tb_multu_ctrl.sv
// Randomised scoreboard bench for multu_ctrl: expected 64-bit products are queued at issue
// and a monitor compares HI/LO on the cycle after each done pulse.
module tb_multu_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mfhi_req;
  logic        mflo_req;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        stall;
  logic        done;

  multu_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .mfhi_req (mfhi_req),
    .mflo_req (mflo_req),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .stall    (stall),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  logic        prev_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a finished product becomes visible the cycle after done.
  initial begin
    logic [63:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done && !rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result_unexpected: hi=%h lo=%h, expected no result", hi_out, lo_out);
        end else begin
          e = exp_q.pop_front();
          chk("result_hi", {32'b0, hi_out}, {32'b0, e[63:32]});
          chk("result_lo", {32'b0, lo_out}, {32'b0, e[31:0]});
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_until_idle(input bit hold_lo, input bit reassert,
                                input logic [31:0] a2, input logic [31:0] b2,
                                output int cyc, output int dn);
    cyc = 0;
    dn  = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      if (cyc >= 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL busy_timeout: busy for %0d cycles, expected idle after 33", cyc);
        break;
      end
      if (cyc == 0) begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (hold_lo) mflo_req = 1'b1;
      end else begin
        // Writes arriving while busy must be ignored.
        mthi  = 1'($urandom_range(0, 1));
        mtlo  = 1'($urandom_range(0, 1));
        wdata = $urandom;
      end
      if (reassert && cyc == 5) begin
        start = 1'b1;
        op_a  = a2;
        op_b  = b2;
      end
      if (done) dn++;
      chk("hi_hold", {32'b0, hi_out}, {32'b0, model_hi});
      chk("lo_hold", {32'b0, lo_out}, {32'b0, model_lo});
      #1;
      chk("stall_busy", {63'b0, stall}, {63'b0, start | mfhi_req | mflo_req | mthi | mtlo});
      cyc++;
    end
    mthi = 1'b0;
    mtlo = 1'b0;
    #1;
    chk("stall_idle", {63'b0, stall}, 64'd0);
    mflo_req = 1'b0;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit hold_lo,
                         input bit mt_with_start, input bit reassert,
                         input logic [31:0] a2, input logic [31:0] b2);
    int cyc;
    int dn;
    logic [63:0] p;
    logic [63:0] p2;
    @(negedge clk);
    p     = 64'(a) * 64'(b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    exp_q.push_back(p);
    if (mt_with_start) begin
      mthi     = 1'b1;
      mtlo     = 1'b1;
      wdata    = $urandom;
      model_hi = wdata;
      model_lo = wdata;
    end
    run_until_idle(hold_lo, reassert, a2, b2, cyc, dn);
    chk("busy_cycles", 64'(cyc), 64'd33);
    chk("done_pulses", 64'(dn), 64'd1);
    if (hold_lo) chk("lo_at_idle", {32'b0, lo_out}, {32'b0, p[31:0]});
    model_hi = p[63:32];
    model_lo = p[31:0];
    if (reassert) begin
      p2 = 64'(a2) * 64'(b2);
      exp_q.push_back(p2);
      run_until_idle(1'b0, 1'b0, 32'd0, 32'd0, cyc, dn);
      chk("busy_cycles_2", 64'(cyc), 64'd33);
      chk("done_pulses_2", 64'(dn), 64'd1);
      model_hi = p2[63:32];
      model_lo = p2[31:0];
    end
  endtask

  task automatic run_abort(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] dropped;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    exp_q.push_back(64'(a) * 64'(b));
    // Eleven edges after acceptance the iteration count reads 10.
    repeat (11) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort_no_done", {63'b0, done}, 64'd0);
    end
    rst     = 1'b1;
    dropped = exp_q.pop_back();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_hi", {32'b0, hi_out}, 64'd0);
    chk("abort_lo", {32'b0, lo_out}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    repeat (40) begin
      @(negedge clk);
      chk("abort_quiet", {63'b0, done}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst      = 1'b1;
    start    = 1'b1;
    op_a     = 32'h1234;
    op_b     = 32'h5678;
    mfhi_req = 1'b1;
    mflo_req = 1'b0;
    mthi     = 1'b1;
    mtlo     = 1'b1;
    wdata    = 32'hA5A5A5A5;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_hi", {32'b0, hi_out}, 64'd0);
    chk("reset_lo", {32'b0, lo_out}, 64'd0);
    #1;
    chk("reset_stall", {63'b0, stall}, 64'd0);
    rst      = 1'b0;
    start    = 1'b0;
    mfhi_req = 1'b0;
    mthi     = 1'b0;
    mtlo     = 1'b0;

    run_mul(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    @(negedge clk);
    mthi     = 1'b1;
    mtlo     = 1'b1;
    mfhi_req = 1'b1;
    wdata    = 32'hDEADBEEF;
    #1;
    chk("mt_idle_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    mthi     = 1'b0;
    mtlo     = 1'b0;
    mfhi_req = 1'b0;
    chk("mthi_write", {32'b0, hi_out}, 64'hDEADBEEF);
    chk("mtlo_write", {32'b0, lo_out}, 64'hDEADBEEF);
    model_hi = 32'hDEADBEEF;
    model_lo = 32'hDEADBEEF;
    run_mul(32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    run_mul(32'h89ABCDEF, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    run_mul(32'h0000FFFF, 32'h80000001, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h7FFFFFFF);
    run_mul(32'h00000007, 32'h00000009, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    run_abort(32'h13572468, 32'h24681357);
    run_mul(32'h80000000, 32'h00000002, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 3) ra = 32'd0;
      if (i == 7) rb = 32'hFFFFFFFF;
      run_mul(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multu_ctrl.md
MULTU_CTRL -- requirements
Module: multu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed as name, direction, width, meaning.
REQ-002 clk  input  1  single pipeline clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 start  input  1  MULTU in EX stage this cycle; request to begin unsigned 32x32 multiply.
REQ-005 op_a  input  32  multiplicand (rs value), sampled only when start is accepted.
REQ-006 op_b  input  32  multiplier (rt value), sampled only when start is accepted.
REQ-007 mfhi_req  input  1  MFHI in EX stage this cycle; needs hi_out.
REQ-008 mflo_req  input  1  MFLO in EX stage this cycle; needs lo_out.
REQ-009 mthi  input  1  MTHI in EX stage; write wdata to HI.
REQ-010 mtlo  input  1  MTLO in EX stage; write wdata to LO.
REQ-011 wdata  input  32  write data for mthi/mtlo.
REQ-012 hi_out  output  32  HI register contents.
REQ-013 lo_out  output  32  LO register contents.
REQ-014 busy  output  1  high when state != IDLE.
REQ-015 stall  output  1  freeze PC, IF/ID, ID/EX; insert bubble into EX/MEM.
REQ-016 done  output  1  high for exactly the one cycle the FSM is in DONE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-018 In IDLE with start=1 at an edge: load product[63:0] = {32'b0, op_b}, multiplicand = op_a, count = 0, go to RUN.
REQ-019 In RUN each edge: if product[0]=1, sum[32:0] = product[63:32] + multiplicand (33-bit, carry kept), else sum = {1'b0, product[63:32]}; product <= {sum, product[31:1]}; count <= count+1.
REQ-020 RUN SHALL execute exactly 32 iterations; the edge performing iteration with count=31 SHALL move the FSM to DONE.
REQ-021 In DONE at the next edge: HI <= product[63:32], LO <= product[31:0], go to IDLE.
REQ-022 Latency: start accepted at edge E0 -> done high between E32 and E33 -> hi_out/lo_out hold the new product after E33; next start may be accepted at E33 or later (IDLE).
REQ-023 hi_out/lo_out SHALL remain unchanged during RUN and DONE (old values visible until E33).
REQ-024 stall SHALL be combinational: stall = busy & (start | mfhi_req | mflo_req | mthi | mtlo).
REQ-025 start, mthi, mtlo arriving while busy SHALL be ignored by the FSM/registers (the stall holds them in EX until IDLE).
REQ-026 In IDLE, mthi=1 SHALL write HI <= wdata and mtlo=1 SHALL write LO <= wdata on the edge; both may fire together.
REQ-027 In IDLE, start together with mthi or mtlo: start SHALL be accepted and the mthi/mtlo write SHALL also take effect, but is overwritten by the product at completion.
REQ-028 stall SHALL be 0 whenever busy=0; no request is stalled in IDLE.
REQ-029 Product SHALL be unsigned modulo 2^64; no overflow or exception output.

Reset
REQ-030 On rst=1 at an edge: state IDLE, count 0, product 0, multiplicand 0, HI 0, LO 0.
REQ-031 After reset: busy=0, done=0, stall=0, hi_out=0, lo_out=0.
REQ-032 rst SHALL take priority over start, mthi, mtlo and any in-flight multiply; reset mid-RUN or DONE aborts with no HI/LO update.

Verification
REQ-033 op_a=3, op_b=5, start 1 cycle -> busy high 33 cycles, done pulses once, then HI=0x00000000, LO=0x0000000F.
REQ-034 op_a=op_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 (carry path exercised).
REQ-035 mflo_req held high from cycle after start -> stall=1 every cycle until IDLE, 0 on first IDLE cycle with lo_out=new product.
REQ-036 rst asserted with count=10 in RUN -> next cycle busy=0, HI=LO=0, no done pulse.
REQ-037 IDLE: mthi=1, mtlo=1, wdata=0xDEADBEEF -> HI=LO=0xDEADBEEF, stall stays 0; then start with op_a=0x10000, op_b=0x10000 -> HI=0x00000001, LO=0x00000000.
REQ-038 start reasserted while busy -> ignored, stall=1; accepted on first IDLE edge; second result correct.
